mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port word-addressed SOC RAM.
- Requester m0 is the Processor; m1 is a second bus master such as a UART program loader or debug port.
- Each requester uses a strobe interface (rstrb, wmask) plus rbusy/wbusy wait signals.
- Requests are registered, arbitrated (round-robin or fixed priority) and issued to the RAM one at a time. Read data is returned to the requester that issued the read.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM between two strobe-based requesters (m0 = CPU, m1 = loader/debug).
// Requests are registered, arbitrated in IDLE and issued one at a time; read data returns to its issuer.
module mem_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wmask,
  output logic        ram_rstrb,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_wmask [2];
  logic [31:0] r_rdata [2];
  logic [1:0]  r_pend;
  logic [1:0]  r_rbusy;
  logic [1:0]  r_wbusy;
  logic        r_last;
  logic        r_win;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [3:0]  r_ram_wmask;
  logic        r_ram_rstrb;

  logic [31:0] w_addr  [2];
  logic [31:0] w_wdata [2];
  logic [3:0]  w_wmask [2];
  logic [1:0]  w_rstrb;
  logic        w_win;

  assign w_addr[0]  = m0_addr;
  assign w_addr[1]  = m1_addr;
  assign w_wdata[0] = m0_wdata;
  assign w_wdata[1] = m1_wdata;
  assign w_wmask[0] = m0_wmask;
  assign w_wmask[1] = m1_wmask;
  assign w_rstrb    = {m1_rstrb, m0_rstrb};

  // Tie goes to the port that was not granted last (round robin) or to m0 (fixed).
  always_comb begin
    w_win = r_pend[1];
    if (r_pend[0] && r_pend[1]) begin
      w_win = ROUND_ROBIN ? ~r_last : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_pend      <= 2'b00;
      r_rbusy     <= 2'b00;
      r_wbusy     <= 2'b00;
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_ram_addr  <= 32'h0;
      r_ram_wdata <= 32'h0;
      r_ram_wmask <= 4'h0;
      r_ram_rstrb <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]  <= 32'h0;
        r_wdata[i] <= 32'h0;
        r_wmask[i] <= 4'h0;
        r_rdata[i] <= 32'h0;
      end
    end else begin
      // A busy port cannot be re-captured, so capture never collides with the clears below.
      for (int i = 0; i < 2; i++) begin
        if (!r_rbusy[i] && !r_wbusy[i] && (w_rstrb[i] || (w_wmask[i] != 4'h0))) begin
          r_addr[i]  <= w_addr[i];
          r_wdata[i] <= w_wdata[i];
          r_wmask[i] <= w_wmask[i];
          r_pend[i]  <= 1'b1;
          if (w_wmask[i] != 4'h0) begin
            r_wbusy[i] <= 1'b1;
          end else begin
            r_rbusy[i] <= 1'b1;
          end
        end
      end

      case (r_state)
        IDLE: begin
          if (r_pend != 2'b00) begin
            r_win       <= w_win;
            r_last      <= w_win;
            r_ram_addr  <= r_addr[w_win];
            r_ram_wdata <= r_wdata[w_win];
            if (r_wmask[w_win] != 4'h0) begin
              r_ram_wmask <= r_wmask[w_win];
            end else begin
              r_ram_rstrb <= 1'b1;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_ram_rstrb <= 1'b0;
          r_ram_wmask <= 4'h0;
          if (r_ram_wmask != 4'h0) begin
            r_pend[r_win]  <= 1'b0;
            r_wbusy[r_win] <= 1'b0;
            r_state        <= IDLE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_rdata[r_win] <= ram_rdata;
          r_pend[r_win]  <= 1'b0;
          r_rbusy[r_win] <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_rdata  = r_rdata[0];
  assign m1_rdata  = r_rdata[1];
  assign m0_rbusy  = r_rbusy[0];
  assign m1_rbusy  = r_rbusy[1];
  assign m0_wbusy  = r_wbusy[0];
  assign m1_wbusy  = r_wbusy[1];
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wmask = r_ram_wmask;
  assign ram_rstrb = r_ram_rstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a round-robin instance (d1) and a fixed-priority instance (d0) share stimulus,
// each with its own behavioural RAM.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;

  logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_ram_addr, d1_ram_wdata, d1_ram_rdata;
  logic        d1_m0_rbusy, d1_m0_wbusy, d1_m1_rbusy, d1_m1_wbusy, d1_ram_rstrb;
  logic [3:0]  d1_ram_wmask;
  logic [31:0] d0_m0_rdata, d0_m1_rdata, d0_ram_addr, d0_ram_wdata, d0_ram_rdata;
  logic        d0_m0_rbusy, d0_m0_wbusy, d0_m1_rbusy, d0_m1_wbusy, d0_ram_rstrb;
  logic [3:0]  d0_ram_wmask;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem0 [0:255];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ROUND_ROBIN(1'b1)) dut1 (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(d1_m0_rdata), .m0_rbusy(d1_m0_rbusy), .m0_wbusy(d1_m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(d1_m1_rdata), .m1_rbusy(d1_m1_rbusy), .m1_wbusy(d1_m1_wbusy),
    .ram_addr(d1_ram_addr), .ram_wdata(d1_ram_wdata), .ram_wmask(d1_ram_wmask),
    .ram_rstrb(d1_ram_rstrb), .ram_rdata(d1_ram_rdata)
  );

  mem_arbiter #(.ROUND_ROBIN(1'b0)) dut0 (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(d0_m0_rdata), .m0_rbusy(d0_m0_rbusy), .m0_wbusy(d0_m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(d0_m1_rdata), .m1_rbusy(d0_m1_rbusy), .m1_wbusy(d0_m1_wbusy),
    .ram_addr(d0_ram_addr), .ram_wdata(d0_ram_wdata), .ram_wmask(d0_ram_wmask),
    .ram_rstrb(d0_ram_rstrb), .ram_rdata(d0_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs: byte-masked write, read data valid the cycle after the strobe.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (d1_ram_wmask[b]) mem1[d1_ram_addr[9:2]][8*b +: 8] = d1_ram_wdata[8*b +: 8];
      if (d0_ram_wmask[b]) mem0[d0_ram_addr[9:2]][8*b +: 8] = d0_ram_wdata[8*b +: 8];
    end
    if (d1_ram_rstrb) d1_ram_rdata <= mem1[d1_ram_addr[9:2]];
    if (d0_ram_rstrb) d0_ram_rdata <= mem0[d0_ram_addr[9:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    m0_rstrb = 1'b0; m0_wmask = 4'h0;
    m1_rstrb = 1'b0; m1_wmask = 4'h0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({d1_m0_rdata, d1_m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {d1_m0_rdata, d1_m1_rdata}); end
    checks++; if ({d1_m0_rbusy, d1_m0_wbusy, d1_m1_rbusy, d1_m1_wbusy} !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", {d1_m0_rbusy, d1_m0_wbusy, d1_m1_rbusy, d1_m1_wbusy}); end
    checks++; if ({d1_ram_addr, d1_ram_wdata, d1_ram_wmask, d1_ram_rstrb} !== 69'h0) begin errors++; $display("FAIL reset_ram: got %h expected 0", {d1_ram_addr, d1_ram_wdata, d1_ram_wmask, d1_ram_rstrb}); end
  endtask

  task automatic test_read();
    m0_addr = 32'd400; m0_rstrb = 1'b1;
    step(); clear_strobes();
    checks++; if (d1_m0_rbusy !== 1'b1) begin errors++; $display("FAIL read_rbusy_t: got %b expected 1", d1_m0_rbusy); end
    step();
    checks++; if ({d1_ram_rstrb, d1_ram_addr} !== {1'b1, 32'd400}) begin errors++; $display("FAIL read_issue: got %h expected %h", {d1_ram_rstrb, d1_ram_addr}, {1'b1, 32'd400}); end
    step();
    checks++; if ({d1_ram_rstrb, d1_m0_rbusy} !== 2'b01) begin errors++; $display("FAIL read_wait: got %b expected 01", {d1_ram_rstrb, d1_m0_rbusy}); end
    step();
    checks++; if ({d1_m0_rdata, d1_m0_rbusy} !== {32'h04030201, 1'b0}) begin errors++; $display("FAIL read_done: got %h expected %h", {d1_m0_rdata, d1_m0_rbusy}, {32'h04030201, 1'b0}); end
    checks++; if ({d1_m1_rdata, d1_m1_rbusy, d1_m1_wbusy} !== 34'h0) begin errors++; $display("FAIL read_m1_quiet: got %h expected 0", {d1_m1_rdata, d1_m1_rbusy, d1_m1_wbusy}); end
  endtask

  task automatic test_write();
    m1_addr = 32'd404; m1_wdata = 32'hAABBCCDD; m1_wmask = 4'b0100;
    step(); clear_strobes();
    checks++; if ({d1_m1_wbusy, d1_m1_rbusy} !== 2'b10) begin errors++; $display("FAIL write_busy_t: got %b expected 10", {d1_m1_wbusy, d1_m1_rbusy}); end
    step();
    checks++; if ({d1_ram_wmask, d1_ram_addr, d1_ram_wdata, d1_ram_rstrb} !== {4'b0100, 32'd404, 32'hAABBCCDD, 1'b0}) begin errors++; $display("FAIL write_issue: got %h expected %h", {d1_ram_wmask, d1_ram_addr, d1_ram_wdata, d1_ram_rstrb}, {4'b0100, 32'd404, 32'hAABBCCDD, 1'b0}); end
    step();
    checks++; if ({d1_ram_wmask, d1_m1_wbusy} !== 5'b0) begin errors++; $display("FAIL write_done: got %b expected 00000", {d1_ram_wmask, d1_m1_wbusy}); end
    checks++; if (d1_ram_addr !== 32'd404) begin errors++; $display("FAIL write_addr_hold: got %h expected %h", d1_ram_addr, 32'd404); end
    m0_addr = 32'd404; m0_rstrb = 1'b1;
    step(); clear_strobes();
    repeat (3) step();
    checks++; if ({d1_m0_rdata, d1_m0_rbusy} !== {32'h08BB0605, 1'b0}) begin errors++; $display("FAIL write_readback: got %h expected %h", {d1_m0_rdata, d1_m0_rbusy}, {32'h08BB0605, 1'b0}); end
  endtask

  task automatic test_rr_contention();
    apply_reset();
    m0_addr = 32'd400; m1_addr = 32'd404; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    step(); clear_strobes();
    checks++; if ({d1_m0_rbusy, d1_m1_rbusy} !== 2'b11) begin errors++; $display("FAIL rr_both_busy: got %b expected 11", {d1_m0_rbusy, d1_m1_rbusy}); end
    step();
    checks++; if ({d1_ram_rstrb, d1_ram_addr} !== {1'b1, 32'd400}) begin errors++; $display("FAIL rr_a_first: got %h expected %h", {d1_ram_rstrb, d1_ram_addr}, {1'b1, 32'd400}); end
    step(); step();
    checks++; if ({d1_m0_rdata, d1_m0_rbusy, d1_m1_rbusy} !== {32'h04030201, 2'b01}) begin errors++; $display("FAIL rr_a_m0_done: got %h expected %h", {d1_m0_rdata, d1_m0_rbusy, d1_m1_rbusy}, {32'h04030201, 2'b01}); end
    step();
    checks++; if ({d1_ram_rstrb, d1_ram_addr} !== {1'b1, 32'd404}) begin errors++; $display("FAIL rr_a_second: got %h expected %h", {d1_ram_rstrb, d1_ram_addr}, {1'b1, 32'd404}); end
    step(); step();
    checks++; if ({d1_m1_rdata, d1_m1_rbusy} !== {32'h08BB0605, 1'b0}) begin errors++; $display("FAIL rr_a_m1_done: got %h expected %h", {d1_m1_rdata, d1_m1_rbusy}, {32'h08BB0605, 1'b0}); end

    // A lone m0 read leaves m0 as last grant, so the next tie must go to m1.
    m0_addr = 32'd404; m0_rstrb = 1'b1;
    step(); clear_strobes();
    repeat (3) step();
    checks++; if (d1_m0_rdata !== 32'h08BB0605) begin errors++; $display("FAIL rr_single: got %h expected %h", d1_m0_rdata, 32'h08BB0605); end

    m0_addr = 32'd400; m1_addr = 32'd404; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    step(); clear_strobes();
    step();
    checks++; if ({d1_ram_rstrb, d1_ram_addr} !== {1'b1, 32'd404}) begin errors++; $display("FAIL rr_b_m1_first: got %h expected %h", {d1_ram_rstrb, d1_ram_addr}, {1'b1, 32'd404}); end
    checks++; if ({d0_ram_rstrb, d0_ram_addr} !== {1'b1, 32'd400}) begin errors++; $display("FAIL fixed_b_m0_first: got %h expected %h", {d0_ram_rstrb, d0_ram_addr}, {1'b1, 32'd400}); end
    step(); step();
    checks++; if ({d1_m1_rbusy, d1_m0_rbusy} !== 2'b01) begin errors++; $display("FAIL rr_b_mid: got %b expected 01", {d1_m1_rbusy, d1_m0_rbusy}); end
    step(); step(); step();
    checks++; if ({d1_m0_rdata, d1_m0_rbusy} !== {32'h04030201, 1'b0}) begin errors++; $display("FAIL rr_b_m0_done: got %h expected %h", {d1_m0_rdata, d1_m0_rbusy}, {32'h04030201, 1'b0}); end
  endtask

  task automatic test_fixed_priority();
    int run = 0;
    int m1_served = 0;
    logic prev_m0_busy = 1'b0;
    bit drained = 1'b0;
    apply_reset();
    m0_addr = 32'd400; m1_addr = 32'd404;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (d0_ram_rstrb && d0_ram_addr == 32'd404) begin
        m1_served++;
        checks++; if (prev_m0_busy !== 1'b0) begin errors++; $display("FAIL fixed_m1_while_m0_pending: got m0 pending %b expected 0 (cycle %0d)", prev_m0_busy, cyc); end
      end
      if (d0_m0_rbusy) begin
        run++;
      end else begin
        if (run > 0) begin
          checks++; if (run > 5) begin errors++; $display("FAIL fixed_m0_delay: got %0d busy cycles expected at most 5", run); end
        end
        run = 0;
      end
      prev_m0_busy = d0_m0_rbusy;
      m0_rstrb = (cyc < 20) && !d0_m0_rbusy;
      m1_rstrb = (cyc < 20) && !d0_m1_rbusy;
      step();
    end
    clear_strobes();
    checks++; if (m1_served < 1) begin errors++; $display("FAIL fixed_m1_served: got %0d expected at least 1", m1_served); end
    for (int k = 0; k < 20 && !drained; k++) begin
      if (!(d0_m0_rbusy | d0_m1_rbusy | d1_m0_rbusy | d1_m1_rbusy)) drained = 1'b1;
      else step();
    end
    checks++; if (!drained) begin errors++; $display("FAIL fixed_drain: got busy after 20 cycles expected idle"); end
  endtask

  task automatic test_reset_in_wait();
    m0_addr = 32'd404; m0_rstrb = 1'b1;
    step(); clear_strobes();
    step(); step();
    checks++; if ({d1_ram_rstrb, d1_m0_rbusy} !== 2'b01) begin errors++; $display("FAIL rst_wait_state: got %b expected 01", {d1_ram_rstrb, d1_m0_rbusy}); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    checks++; if ({d1_m0_rdata, d1_m1_rdata, d1_m0_rbusy, d1_m1_rbusy, d1_m0_wbusy, d1_m1_wbusy} !== 68'h0) begin errors++; $display("FAIL rst_wait_ports: got %h expected 0", {d1_m0_rdata, d1_m1_rdata, d1_m0_rbusy, d1_m1_rbusy, d1_m0_wbusy, d1_m1_wbusy}); end
    checks++; if ({d1_ram_addr, d1_ram_wdata, d1_ram_wmask, d1_ram_rstrb} !== 69'h0) begin errors++; $display("FAIL rst_wait_ram: got %h expected 0", {d1_ram_addr, d1_ram_wdata, d1_ram_wmask, d1_ram_rstrb}); end
    m0_addr = 32'd400; m0_rstrb = 1'b1;
    step(); clear_strobes();
    step(); step();
    checks++; if (d1_m0_rbusy !== 1'b1) begin errors++; $display("FAIL rst_fresh_busy: got %b expected 1", d1_m0_rbusy); end
    step();
    checks++; if ({d1_m0_rdata, d1_m0_rbusy} !== {32'h04030201, 1'b0}) begin errors++; $display("FAIL rst_fresh_read: got %h expected %h", {d1_m0_rdata, d1_m0_rbusy}, {32'h04030201, 1'b0}); end
  endtask

  task automatic test_read_write_collision();
    m0_addr = 32'd408; m0_wdata = 32'h11223344; m0_wmask = 4'b1111; m0_rstrb = 1'b1;
    step(); clear_strobes();
    checks++; if ({d1_m0_wbusy, d1_m0_rbusy} !== 2'b10) begin errors++; $display("FAIL rw_busy: got %b expected 10", {d1_m0_wbusy, d1_m0_rbusy}); end
    m0_rstrb = 1'b1;
    step(); m0_rstrb = 1'b0;
    checks++; if ({d1_ram_wmask, d1_ram_rstrb, d1_m0_rbusy} !== {4'b1111, 2'b00}) begin errors++; $display("FAIL rw_issue: got %b expected 111100", {d1_ram_wmask, d1_ram_rstrb, d1_m0_rbusy}); end
    step();
    checks++; if ({d1_ram_wmask, d1_ram_rstrb, d1_m0_wbusy, d1_m0_rbusy} !== 7'b0) begin errors++; $display("FAIL rw_done: got %b expected 0000000", {d1_ram_wmask, d1_ram_rstrb, d1_m0_wbusy, d1_m0_rbusy}); end
    step();
    checks++; if (d1_ram_rstrb !== 1'b0) begin errors++; $display("FAIL rw_no_extra_read: got %b expected 0", d1_ram_rstrb); end
    m0_rstrb = 1'b1;
    step(); clear_strobes();
    repeat (3) step();
    checks++; if (d1_m0_rdata !== 32'h11223344) begin errors++; $display("FAIL rw_readback: got %h expected %h", d1_m0_rdata, 32'h11223344); end
  endtask

  initial begin
    resetn = 1'b0;
    m0_addr = 32'h0; m0_wdata = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    clear_strobes();
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h0;
      mem0[i] = 32'h0;
    end
    mem1[100] = 32'h04030201; mem1[101] = 32'h08070605;
    mem0[100] = 32'h04030201; mem0[101] = 32'h08070605;
    step();
    test_reset();
    test_read();
    test_write();
    test_rr_contention();
    test_fixed_priority();
    test_reset_in_wait();
    test_read_write_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
